// File: rtl/imem_ctrl_pkg.sv
// Shared CPU definitions: instruction-memory defaults, controller FSM encoding
// and the ISA opcode map.
package imem_ctrl_pkg;

    localparam int                     IMEM_DATA_W  = 16;
    localparam int                     IMEM_ADDR_W  = 9;
    localparam logic [IMEM_DATA_W-1:0] IMEM_CLR_VAL = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

    // Top nibble of every instruction word.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LD  = 4'h6,
        OP_ST  = 4'h7,
        OP_BEQ = 4'h8,
        OP_JMP = 4'h9
    } isa_opcode_e;

    function automatic isa_opcode_e opcode_of(input logic [IMEM_DATA_W-1:0] insn);
        return isa_opcode_e'(insn[IMEM_DATA_W-1 -: 4]);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port and one registered read port. The array
// itself is never reset; only the read-data register is.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read data holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: clears the array after reset, accepts load
// bursts (valid/ready) and serves single-cycle-latency fetches while idle.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int                DATA_W  = IMEM_DATA_W,
    parameter int                ADDR_W  = IMEM_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(IMEM_CLR_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_wrap,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output imem_state_e       o_dbg_state
);

    localparam int DEPTH = 2**ADDR_W;

    // Load handshake: a word transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_ready is high only in LOAD, and the source
    // may hold ld_valid low for any number of cycles.
    imem_state_e       r_state;
    imem_state_e       w_next_state;
    logic [ADDR_W-1:0] r_sweep_addr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_ld_count;
    logic              r_ld_wrap;
    logic              r_ld_done;
    logic              r_if_valid;

    logic              w_accept;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_rd_en;

    assign w_accept = ld_ready && ld_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_sweep_addr == ADDR_W'(DEPTH - 1)) w_next_state = ST_IDLE;
            ST_IDLE:  if (ld_start)                           w_next_state = ST_LOAD;
            ST_LOAD:  if (ld_valid && ld_last)                w_next_state = ST_IDLE;
            default:                                          w_next_state = ST_CLEAR;
        endcase
    end

    // Writes and reads are confined to disjoint states, so the array never
    // sees a read and a write to the same address in one cycle.
    always_comb begin
        busy      = 1'b1;
        ld_ready  = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = r_sweep_addr;
        w_wr_data = CLR_VAL;
        w_rd_en   = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_wr_en = 1'b1;
            end
            ST_IDLE: begin
                busy    = 1'b0;
                w_rd_en = if_req;
            end
            ST_LOAD: begin
                ld_ready  = 1'b1;
                w_wr_en   = ld_valid;
                w_wr_addr = r_wr_ptr;
                w_wr_data = ld_data;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_addr <= '0;
            r_wr_ptr     <= '0;
            r_ld_count   <= '0;
            r_ld_wrap    <= 1'b0;
            r_ld_done    <= 1'b0;
            r_if_valid   <= 1'b0;
        end else begin
            r_ld_done  <= w_accept && ld_last;
            r_if_valid <= w_rd_en;
            if (r_state == ST_CLEAR) begin
                r_sweep_addr <= r_sweep_addr + 1'b1;
            end
            if (r_state == ST_IDLE && ld_start) begin
                r_wr_ptr   <= ld_base;
                r_ld_count <= '0;
                r_ld_wrap  <= 1'b0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
                    r_ld_wrap <= 1'b1;
                end
                if (r_ld_count != (ADDR_W + 1)'(DEPTH)) begin
                    r_ld_count <= r_ld_count + 1'b1;
                end
            end
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (if_addr),
        .o_rd_data (if_rdata)
    );

    assign ld_done     = r_ld_done;
    assign ld_count    = r_ld_count;
    assign ld_wrap     = r_ld_wrap;
    assign if_valid    = r_if_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl with a 16-word array and a non-zero fill
// word; fetch results are checked against a scoreboard queue.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    localparam int             DW    = 16;
    localparam int             AW    = 4;
    localparam int             DEPTH = 16;
    localparam logic [DW-1:0]  CLR   = 16'hC1C1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          busy;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_done;
    logic [AW:0]   ld_count;
    logic          ld_wrap;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    imem_state_e   dbg_state;

    imem_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .CLR_VAL (CLR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy        (busy),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_done     (ld_done),
        .ld_count    (ld_count),
        .ld_wrap     (ld_wrap),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [DEPTH];
    int            m_ptr;
    int            m_cnt;
    bit            m_wrap;
    logic          drv_hit = 1'b0;
    logic          r_exp_valid;
    logic [DW-1:0] hold = '0;
    bit            mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected if_valid: one cycle after a fetch the model says must hit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_exp_valid <= 1'b0;
        else        r_exp_valid <= drv_hit;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("if_valid", if_valid, r_exp_valid);
            if (r_exp_valid && exp_q.size() > 0) begin
                hold = exp_q.pop_front();
                check_eq("if_rdata", if_rdata, hold);
            end else if (!r_exp_valid) begin
                check_eq("if_rdata_hold", if_rdata, hold);
            end
        end
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; drv_hit = 1'b0;
        ld_start = 1'b0; ld_base = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic fetch(input logic [AW-1:0] a, input bit hit);
        if_req = 1'b1; if_addr = a; drv_hit = hit;
        if (hit) exp_q.push_back(model[a]);
        cycle();
    endtask

    task automatic fetch_all();
        for (int a = 0; a < DEPTH; a++) fetch(AW'(a), 1'b1);
        cycle();
    endtask

    task automatic start_load(input logic [AW-1:0] base);
        ld_start = 1'b1; ld_base = base;
        m_ptr = int'(base); m_cnt = 0; m_wrap = 1'b0;
        cycle();
        check_eq("ld_ready_in_load", ld_ready, 1'b1);
        check_eq("busy_in_load", busy, 1'b1);
        check_eq("ld_count_start", ld_count, 0);
        check_eq("ld_wrap_start", ld_wrap, 1'b0);
    endtask

    task automatic load_word(input logic [DW-1:0] d, input bit last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        model[m_ptr] = d;
        if (m_ptr == DEPTH - 1) m_wrap = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
        cycle();
        check_eq("ld_count", ld_count, m_cnt);
        check_eq("ld_wrap", ld_wrap, m_wrap);
    endtask

    task automatic check_load_end();
        check_eq("ld_done_pulse", ld_done, 1'b1);
        check_eq("busy_after_load", busy, 1'b0);
        check_eq("ld_ready_idle", ld_ready, 1'b0);
        cycle();
        check_eq("ld_done_one_cycle", ld_done, 1'b0);
    endtask

    task automatic wait_clear();
        int n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check_eq("ld_done_in_clear", ld_done, 1'b0);
            if (!busy) break;
            n++;
        end
        check_eq("clear_busy_cycles", n, DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        hold = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = CLR;
        m_ptr = 0; m_cnt = 0; m_wrap = 1'b0;
        #2;
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_state", dbg_state, ST_CLEAR);
        check_eq("rst_ld_count", ld_count, 0);
        check_eq("rst_ld_wrap", ld_wrap, 1'b0);
        check_eq("rst_ld_done", ld_done, 1'b0);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_ld_ready", ld_ready, 1'b0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear();
    endtask

    initial begin
        clear_inputs();
        #2;
        apply_reset();
        check_eq("idle_ld_ready", ld_ready, 1'b0);
        fetch_all();

        // Three-word burst at base 3
        start_load(4'd3);
        load_word(16'hA001, 1'b0);
        load_word(16'hA002, 1'b0);
        load_word(16'hA003, 1'b1);
        check_load_end();
        fetch(4'd3, 1'b1); fetch(4'd4, 1'b1); fetch(4'd5, 1'b1);
        cycle();

        // Fetches during LOAD are dropped; stalls change nothing
        start_load(4'd9);
        fetch(4'd7, 1'b0);
        check_eq("stall_count", ld_count, 0);
        load_word(16'hB001, 1'b0);
        fetch(4'd3, 1'b0);
        load_word(16'hB002, 1'b1);
        check_load_end();

        // Fetch and ld_start in the same idle cycle
        if_req = 1'b1; if_addr = 4'd9; drv_hit = 1'b1;
        exp_q.push_back(model[9]);
        ld_start = 1'b1; ld_base = 4'd0;
        m_ptr = 0; m_cnt = 0; m_wrap = 1'b0;
        cycle();
        check_eq("combo_ld_ready", ld_ready, 1'b1);
        load_word(16'hD000, 1'b0);
        load_word(16'hD001, 1'b1);
        check_load_end();

        // Gapped burst with a stray ld_start mid-burst
        start_load(4'd8);
        load_word(16'hE000, 1'b0);
        cycle();
        load_word(16'hE001, 1'b0);
        ld_start = 1'b1; ld_base = 4'd0;
        cycle();
        check_eq("ignored_start_count", ld_count, m_cnt);
        load_word(16'hE002, 1'b0);
        cycle();
        cycle();
        load_word(16'hE003, 1'b1);
        check_eq("gapped_count", ld_count, 4);
        check_load_end();
        fetch_all();

        // Wrapping burst from base 14
        start_load(4'd14);
        for (int i = 0; i < 5; i++) load_word(16'hF000 + 16'(i), i == 4);
        check_eq("wrap_set", ld_wrap, 1'b1);
        check_eq("wrap_count", ld_count, 5);
        check_load_end();
        fetch_all();

        // Reset in the middle of a burst
        start_load(4'd5);
        load_word(16'h7001, 1'b0);
        load_word(16'h7002, 1'b0);
        apply_reset();
        check_eq("post_rst_count", ld_count, 0);
        fetch_all();
        cycle();
        cycle();

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
